// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single refill/store memory port between the ICache and DCache
// controllers. Arbitration is fixed-priority DCache first. An ICache
// starvation guard overrides that priority once the ICache has waited
// MAX_WAIT cycles. Each grant is locked until the memory answers, and the
// request fields are captured at grant time.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   icache_*          ICache read request (valid/addr) and completion
//                     (ready pulse, refill line)
//   dcache_*          DCache request (valid/for_store/addr/wdata/wstrb) and
//                     completion (ready pulse, refill line)
//   mem_*             memory port: registered request held until mem_ready,
//                     with read line returned alongside mem_ready
//   grant_owner       00 = none, 01 = ICache, 10 = DCache
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 128,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_valid,
  input  logic [ADDR_W-1:0] icache_addr,
  output logic              icache_ready,
  output logic [LINE_W-1:0] icache_rdata,
  input  logic              dcache_valid,
  input  logic              dcache_for_store,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [31:0]       dcache_wdata,
  input  logic [3:0]        dcache_wstrb,
  output logic              dcache_ready,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              mem_valid,
  output logic              mem_for_store,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [1:0]        grant_owner
);

  // The encoding doubles as the grant_owner value.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_e;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_e            state_q,     state_d;
  logic [7:0]        wait_cnt_q,  wait_cnt_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic              for_store_q, for_store_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic [3:0]        wstrb_q,     wstrb_d;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    addr_d      = addr_q;
    for_store_d = for_store_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;

    case (state_q)
      IDLE: begin
        // The starvation guard outranks the normal DCache priority.
        if (icache_valid && (wait_cnt_q == MAX_WAIT_C)) begin
          state_d = GNT_I;
        end else if (dcache_valid) begin
          state_d = GNT_D;
        end else if (icache_valid) begin
          state_d = GNT_I;
        end

        if (state_d == GNT_I) begin
          addr_d      = icache_addr;
          for_store_d = 1'b0;
          wdata_d     = '0;
          wstrb_d     = '0;
        end else if (state_d == GNT_D) begin
          addr_d      = dcache_addr;
          for_store_d = dcache_for_store;
          wdata_d     = dcache_wdata;
          // Strobes are meaningless on a refill, so they are forced to zero.
          wstrb_d     = dcache_for_store ? dcache_wstrb : 4'b0000;
        end
      end
      GNT_I, GNT_D: begin
        // Return to IDLE on completion. That IDLE cycle gives the finished
        // requester time to drop valid before the next arbitration.
        if (mem_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // wait_cnt counts ICache waiting cycles. It clears when ICache wins.
    if ((state_d == GNT_I) && (state_q != GNT_I)) begin
      wait_cnt_d = '0;
    end else if (icache_valid && (state_q != GNT_I) && (wait_cnt_q < MAX_WAIT_C)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      addr_q      <= '0;
      for_store_q <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      addr_q      <= addr_d;
      for_store_q <= for_store_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
    end
  end

  assign mem_valid     = (state_q != IDLE);
  assign grant_owner   = state_q;
  assign mem_addr      = addr_q;
  assign mem_for_store = for_store_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;

  // The completion is forwarded in the same cycle as mem_ready, and only to
  // the owner. A mem_ready seen in IDLE produces nothing.
  assign icache_ready = (state_q == GNT_I) && mem_ready;
  assign dcache_ready = (state_q == GNT_D) && mem_ready;
  assign icache_rdata = icache_ready ? mem_rdata : '0;
  assign dcache_rdata = dcache_ready ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Randomized scoreboard bench for mem_port_arbiter. A single stimulus process
// drives both cache controllers and the memory responder once per cycle. It
// keeps a behavioural picture of the shared port: busy/owner, how long the
// ICache has been waiting, and the rule for picking a winner. From that
// picture it pushes the expected grants and completions into queues. A
// separate monitor pops those queues when the DUT presents a grant or a ready
// pulse, and compares the DUT outputs against them.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 128;
  localparam int MAX_WAIT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              icache_valid;
  logic [ADDR_W-1:0] icache_addr;
  logic              icache_ready;
  logic [LINE_W-1:0] icache_rdata;
  logic              dcache_valid;
  logic              dcache_for_store;
  logic [ADDR_W-1:0] dcache_addr;
  logic [31:0]       dcache_wdata;
  logic [3:0]        dcache_wstrb;
  logic              dcache_ready;
  logic [LINE_W-1:0] dcache_rdata;
  logic              mem_valid;
  logic              mem_for_store;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [LINE_W-1:0] mem_rdata;
  logic [1:0]        grant_owner;

  mem_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .LINE_W  (LINE_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .icache_valid    (icache_valid),
    .icache_addr     (icache_addr),
    .icache_ready    (icache_ready),
    .icache_rdata    (icache_rdata),
    .dcache_valid    (dcache_valid),
    .dcache_for_store(dcache_for_store),
    .dcache_addr     (dcache_addr),
    .dcache_wdata    (dcache_wdata),
    .dcache_wstrb    (dcache_wstrb),
    .dcache_ready    (dcache_ready),
    .dcache_rdata    (dcache_rdata),
    .mem_valid       (mem_valid),
    .mem_for_store   (mem_for_store),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_wstrb       (mem_wstrb),
    .mem_ready       (mem_ready),
    .mem_rdata       (mem_rdata),
    .grant_owner     (grant_owner)
  );

  always #5 clk = ~clk;

  // The cycle number increments at every rising edge.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  owner;
    logic [31:0] addr;
    logic        st;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } grant_t;

  typedef struct {
    int unsigned       cyc;
    logic [LINE_W-1:0] rdata;
  } resp_t;

  grant_t gq[$];
  resp_t  icq[$];
  resp_t  dcq[$];

  // Reference picture of the port, owned by the stimulus process.
  bit m_busy;
  int m_owner;
  int m_age;
  int m_lat;
  int ic_waited;
  bit ic_active;
  bit dc_active;
  bit mr_prev;
  int p_ic;
  int p_dc;
  int p_spur;
  int lat_min;
  int lat_max;

  // Monitor state.
  grant_t cur;
  resp_t  rsp;
  bit     have_cur;
  bit     mv_prev;
  bit     idle_next;
  bit     rose;
  bit     due;
  bit     exp_i;
  bit     exp_d;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Runs one cycle: first accounts for the edge that just happened, then
  // drives the new cycle's inputs.
  task automatic applyStimulus();
    int     win;
    int     prev_owner;
    grant_t g;
    resp_t  r;
    win        = 0;
    prev_owner = m_owner;

    if (m_busy) begin
      if (mr_prev) begin
        if (m_owner == 1) ic_active = 1'b0;
        else              dc_active = 1'b0;
        m_busy  = 1'b0;
        m_owner = 0;
      end else begin
        m_age++;
      end
    end else if (icache_valid || dcache_valid) begin
      if (icache_valid && (ic_waited == MAX_WAIT)) win = 1;
      else if (dcache_valid)                       win = 2;
      else                                         win = 1;
    end

    if (icache_valid && (prev_owner != 1)) begin
      if (win == 1)                  ic_waited = 0;
      else if (ic_waited < MAX_WAIT) ic_waited = ic_waited + 1;
    end

    if (win != 0) begin
      g.cyc   = cyc;
      g.owner = 2'(win);
      if (win == 1) begin
        g.addr  = icache_addr;
        g.st    = 1'b0;
        g.wdata = '0;
        g.wstrb = '0;
      end else begin
        g.addr  = dcache_addr;
        g.st    = dcache_for_store;
        g.wdata = dcache_wdata;
        g.wstrb = dcache_for_store ? dcache_wstrb : 4'b0000;
      end
      gq.push_back(g);
      m_busy  = 1'b1;
      m_owner = win;
      m_age   = 0;
      m_lat   = int'($urandom_range(lat_max, lat_min));
    end

    // ICache controller: the address is stable while waiting and scrambled
    // while granted.
    if (!ic_active) begin
      if (int'($urandom_range(99)) < p_ic) begin
        ic_active   = 1'b1;
        icache_addr = $urandom;
      end
    end else if ((m_owner == 1) && ($urandom_range(3) == 0)) begin
      icache_addr = $urandom;
    end
    icache_valid = ic_active;

    // DCache controller: the fields are stable while waiting and scrambled
    // while granted.
    if (!dc_active) begin
      if (int'($urandom_range(99)) < p_dc) begin
        dc_active        = 1'b1;
        dcache_for_store = 1'($urandom_range(1));
        dcache_addr      = $urandom;
        dcache_wdata     = dcache_for_store ? $urandom : 32'h0;
        dcache_wstrb     = dcache_for_store ? 4'($urandom) : 4'h0;
      end
    end else if ((m_owner == 2) && ($urandom_range(3) == 0)) begin
      dcache_addr      = $urandom;
      dcache_wdata     = $urandom;
      dcache_wstrb     = 4'($urandom);
      dcache_for_store = ~dcache_for_store;
    end
    dcache_valid = dc_active;

    // Memory responder. mem_rdata carries garbage outside of ready cycles.
    mem_ready = 1'b0;
    mem_rdata = rand_line();
    if (m_busy && (m_age >= m_lat)) begin
      mem_ready = 1'b1;
      r.cyc     = cyc;
      r.rdata   = mem_rdata;
      if (m_owner == 1) icq.push_back(r);
      else              dcq.push_back(r);
    end else if (!m_busy && (int'($urandom_range(99)) < p_spur)) begin
      mem_ready = 1'b1;
    end
    mr_prev = mem_ready;
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      applyStimulus();
    end
  endtask

  task automatic resetModel();
    m_busy       = 1'b0;
    m_owner      = 0;
    m_age        = 0;
    m_lat        = 0;
    ic_waited    = 0;
    ic_active    = 1'b0;
    dc_active    = 1'b0;
    icache_valid = 1'b0;
    dcache_valid = 1'b0;
    gq.delete();
    icq.delete();
    dcq.delete();
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    have_cur  = 1'b0;
    mv_prev   = 1'b0;
    idle_next = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        have_cur  = 1'b0;
        mv_prev   = 1'b0;
        idle_next = 1'b0;
      end else begin
        rose = mem_valid && !mv_prev;
        due  = (gq.size() > 0) && (gq[0].cyc == cyc);
        if (rose || due) begin
          checkOutput("grant_start", 128'(rose), 128'(due));
          if (due) begin
            cur      = gq.pop_front();
            have_cur = 1'b1;
          end
        end
        if (mem_valid && have_cur) begin
          checkOutput("grant_owner", 128'(grant_owner), 128'(cur.owner));
          checkOutput("mem_addr", 128'(mem_addr), 128'(cur.addr));
          checkOutput("mem_for_store", 128'(mem_for_store), 128'(cur.st));
          checkOutput("mem_wdata", 128'(mem_wdata), 128'(cur.wdata));
          checkOutput("mem_wstrb", 128'(mem_wstrb), 128'(cur.wstrb));
        end
        if (idle_next) begin
          checkOutput("idle_mem_valid", 128'(mem_valid), 128'(0));
          checkOutput("idle_grant_owner", 128'(grant_owner), 128'(0));
          idle_next = 1'b0;
        end

        exp_i = (icq.size() > 0) && (icq[0].cyc == cyc);
        checkOutput("icache_ready", 128'(icache_ready), 128'(exp_i));
        if (exp_i) begin
          rsp = icq.pop_front();
          checkOutput("icache_rdata", 128'(icache_rdata), 128'(rsp.rdata));
          idle_next = 1'b1;
          have_cur  = 1'b0;
        end else begin
          checkOutput("icache_rdata_quiet", 128'(icache_rdata), 128'(0));
        end

        exp_d = (dcq.size() > 0) && (dcq[0].cyc == cyc);
        checkOutput("dcache_ready", 128'(dcache_ready), 128'(exp_d));
        if (exp_d) begin
          rsp = dcq.pop_front();
          checkOutput("dcache_rdata", 128'(dcache_rdata), 128'(rsp.rdata));
          idle_next = 1'b1;
          have_cur  = 1'b0;
        end else begin
          checkOutput("dcache_rdata_quiet", 128'(dcache_rdata), 128'(0));
        end

        mv_prev = mem_valid;
      end
    end
  end

  initial begin
    bit found;

    // Hold reset with both caches requesting and a stray mem_ready.
    rst              = 1'b0;
    icache_valid     = 1'b1;
    icache_addr      = 32'h1C00_0040;
    dcache_valid     = 1'b1;
    dcache_for_store = 1'b1;
    dcache_addr      = 32'h8000_1000;
    dcache_wdata     = 32'h1234_5678;
    dcache_wstrb     = 4'b0011;
    mem_ready        = 1'b1;
    mem_rdata        = {4{32'hAAAA_AAAA}};
    p_ic = 0; p_dc = 0; p_spur = 0; lat_min = 0; lat_max = 3;
    resetModel();
    mr_prev = 1'b0;

    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_mem_valid", 128'(mem_valid), 128'(0));
      checkOutput("rst_icache_ready", 128'(icache_ready), 128'(0));
      checkOutput("rst_dcache_ready", 128'(dcache_ready), 128'(0));
      checkOutput("rst_grant_owner", 128'(grant_owner), 128'(0));
      checkOutput("rst_mem_addr", 128'(mem_addr), 128'(0));
      checkOutput("rst_mem_wstrb", 128'(mem_wstrb), 128'(0));
    end

    // Release reset. Both requests are still pending and DCache must win.
    @(posedge clk);
    #1;
    rst          = 1'b1;
    icache_valid = 1'b1;
    dcache_valid = 1'b1;
    ic_active    = 1'b1;
    dc_active    = 1'b1;
    mr_prev      = mem_ready;

    // Mixed random traffic with stray mem_ready pulses in IDLE.
    p_ic = 40; p_dc = 40; p_spur = 25; lat_min = 0; lat_max = 4;
    runCycles(400);

    // DCache re-requests continuously, so ICache relies on the starvation guard.
    p_ic = 100; p_dc = 100; p_spur = 0; lat_min = 0; lat_max = 2;
    runCycles(300);

    // Reset in the middle of a DCache grant.
    p_ic = 0; p_dc = 100; p_spur = 0; lat_min = 4; lat_max = 6;
    found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      @(posedge clk);
      #1;
      applyStimulus();
      if (m_busy && (m_owner == 2) && (m_age >= 1) && !mem_ready) found = 1'b1;
    end
    if (!found) begin
      total++;
      bad++;
      $display("[TB] FAIL midgrant_setup: got no DCache grant expected one within 80 cycles");
    end else begin
      #2;
      rst       = 1'b0;
      mem_ready = 1'b1;
      #1;
      checkOutput("async_rst_mem_valid", 128'(mem_valid), 128'(0));
      checkOutput("async_rst_grant_owner", 128'(grant_owner), 128'(0));
      checkOutput("async_rst_dcache_ready", 128'(dcache_ready), 128'(0));
      resetModel();
      @(posedge clk);
      #1;
      // A late mem_ready right after release must be ignored in IDLE.
      rst       = 1'b1;
      mem_ready = 1'b1;
      mr_prev   = 1'b1;
    end

    // Starvation traffic again, checking that the wait count restarted at zero.
    p_ic = 100; p_dc = 100; p_spur = 0; lat_min = 0; lat_max = 3;
    runCycles(200);
    p_ic = 50; p_dc = 50; p_spur = 30; lat_min = 0; lat_max = 5;
    runCycles(300);

    // Drain all outstanding requests.
    p_ic = 0; p_dc = 0; p_spur = 0;
    runCycles(60);
    @(negedge clk);
    checkOutput("leftover_expectations", 128'(gq.size() + icq.size() + dcq.size()), 128'(0));
    checkOutput("final_active", 128'({ic_active, dc_active}), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single refill/store memory port between the ICache and DCache controllers.
- Both controllers use the level valid/ready protocol: valid is held until a 1-cycle ready pulse, after which the controller drops valid.
- Arbitration is fixed-priority DCache first, with an ICache starvation guard.
- Each grant is locked for the whole transaction; request fields are registered at grant time.

Parameters:
- ADDR_W, 32, address width.
- LINE_W, 128, refill line width returned on reads.
- MAX_WAIT, 8, cycles ICache may wait while asserting valid before it gains priority (range 1..255).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- icache_valid  input  1  ICache read request.
- icache_addr  input  ADDR_W  ICache line address.
- icache_ready  output  1  1-cycle completion pulse to ICache.
- icache_rdata  output  LINE_W  refill line to ICache.
- dcache_valid  input  1  DCache request.
- dcache_for_store  input  1  1 = store, 0 = refill read.
- dcache_addr  input  ADDR_W  DCache address.
- dcache_wdata  input  32  store data.
- dcache_wstrb  input  4  store byte strobes.
- dcache_ready  output  1  1-cycle completion pulse to DCache.
- dcache_rdata  output  LINE_W  refill line to DCache.
- mem_valid  output  1  request to memory, held until mem_ready.
- mem_for_store  output  1  store/read qualifier.
- mem_addr  output  ADDR_W  registered address.
- mem_wdata  output  32  registered store data.
- mem_wstrb  output  4  registered strobes; 0 on reads.
- mem_ready  input  1  1-cycle completion from memory.
- mem_rdata  input  LINE_W  read line, valid with mem_ready.
- grant_owner  output  2  00 = none, 01 = ICache, 10 = DCache.

Behaviour:

States: IDLE, GNT_I, GNT_D.

Reset (rst=0, asynchronous):
- State goes to IDLE and wait_cnt to 0.
- All registered request fields clear to 0.
- mem_valid, icache_ready, dcache_ready and grant_owner read 0 immediately.
- A reset mid-transaction abandons the transaction; a late mem_ready after reset release is ignored in IDLE.

IDLE:
- mem_valid=0.
- Arbitration:
  - If icache_valid and wait_cnt==MAX_WAIT: grant ICache.
  - Else if dcache_valid: grant DCache.
  - Else if icache_valid: grant ICache.
  - Else stay in IDLE.
- On grant: latch addr, for_store, wdata and wstrb at the clock edge. ICache grants latch for_store=0, wdata=0, wstrb=0.
- Next state is GNT_I or GNT_D.
- Grant latency: a request seen in IDLE gives mem_valid=1 on the next cycle.

GNT_x:
- mem_valid=1 and mem_* are driven from the latched registers. They are stable for the whole grant.
- grant_owner reflects the owner.
- When mem_ready=1, in the same cycle (combinational):
  - owner_ready=1.
  - owner_rdata=mem_rdata.
  - Next state is IDLE.
- The non-owner's ready is always 0 and its rdata is 0.
- Changes on the owner's valid or fields during a grant are ignored; the transaction always completes.
- Minimum 1 IDLE cycle between grants. This guarantees the finished requester has dropped valid before re-arbitration.
- Back-to-back throughput: one transaction per (memory latency + 2) cycles.

wait_cnt (8 bits):
- Increments each cycle that icache_valid=1 and ICache is not in GNT_I.
- Saturates at MAX_WAIT.
- Clears to 0 on the edge entering GNT_I.
- Holds when icache_valid=0.

Simultaneous events:
- Both valid in IDLE with wait_cnt<MAX_WAIT: DCache wins.
- A new request arriving in the same cycle as mem_ready is not seen until IDLE.
- mem_ready while in IDLE is ignored; no ready pulse is produced.

Test Plan:
1. Reset asserted with both valid held → all outputs 0. After release, IDLE; DCache granted on next edge, mem_valid=1 one cycle later; mem_addr=dcache_addr.
2. Only icache_valid, addr=0x1C000040; mem_ready after 3 cycles with rdata=0xAAAA...; → icache_ready pulses 1 cycle with icache_rdata=0xAAAA...; dcache_ready stays 0; grant_owner 01→00.
3. Both valid, wait_cnt=0 → DCache served first. ICache is served after 1 IDLE cycle. A DCache store (for_store=1, wstrb=4'b0011, wdata=0x12345678) appears unchanged on mem_*.
4. MAX_WAIT=8; dcache_valid kept continuously re-requesting, ICache waiting → after wait_cnt hits 8, the next IDLE grants ICache despite dcache_valid=1; wait_cnt returns to 0.
5. DCache changes dcache_addr mid-grant → mem_addr unchanged until mem_ready. mem_ready pulse while in IDLE → no ready pulse to either cache.
6. rst pulsed low while in GNT_D with mem_valid=1 → mem_valid drops immediately without waiting for clk; state IDLE, wait_cnt=0.
